gcd_dispatch: RTL and testbench
===============================

GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width; must equal the gcd core WIDTH.
REQ-002 Parameter DEPTH, default 4, operand FIFO entries; power of two, >= 2.
REQ-003 Parameter TIMEOUT, default 512, watchdog limit in cycles; used only under GCD_DISPATCH_TIMEOUT_EN.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 in_valid_i  in  1  upstream operand pair valid.
REQ-007 in_ready_o  out  1  FIFO can accept; equals !full, registered, no combinational path from any output-side input.
REQ-008 in_a_i, in_b_i  in  WIDTH each  operands.
REQ-009 core_valid_o  out  1  start pulse to the gcd core valid_i.
REQ-010 core_a_o, core_b_o  out  WIDTH each  operands to the gcd core a_i/b_i.
REQ-011 core_valid_i  in  1  gcd core valid_o.
REQ-012 core_gcd_i  in  WIDTH  gcd core gcd_o.
REQ-013 res_valid_o  out  1  result available downstream.
REQ-014 res_ready_i  in  1  downstream accepts the result.
REQ-015 res_gcd_o  out  WIDTH  buffered result.
REQ-016 count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 err_o  out  1  sticky timeout flag; constant 0 without GCD_DISPATCH_TIMEOUT_EN.

Function
REQ-018 Push occurs on a rising edge with in_valid_i && in_ready_o; the entry is visible in count_o the following cycle.
REQ-019 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE -> ISSUE when the FIFO is non-empty and res_valid_o is 0; the head entry is popped and registered onto core_a_o/core_b_o at that edge.
REQ-021 In ISSUE, core_valid_o is 1 for exactly one cycle; next state is WAIT.
REQ-022 core_a_o/core_b_o hold stable from ISSUE through WAIT; the core samples them on the ISSUE edge.
REQ-023 WAIT -> HOLD on core_valid_i; core_gcd_i is captured into res_gcd_o and res_valid_o is set at that edge.
REQ-024 HOLD -> IDLE on res_ready_i; res_valid_o clears at that edge.
REQ-025 res_gcd_o stays stable while res_valid_o && !res_ready_i.
REQ-026 core_valid_i outside WAIT is ignored.
REQ-027 At most one operation is outstanding at the core.
REQ-028 Minimum latency from push into an empty block to res_valid_o, excluding core compute time, is 3 cycles: push, ISSUE, then capture.
REQ-029 A simultaneous push and pop in the same cycle leaves count_o unchanged and preserves FIFO order.
REQ-030 FIFO pointers wrap modulo DEPTH; full occurs at count_o == DEPTH; a push attempted while full is not accepted and not lost, because in_ready_o is 0.

Reset
REQ-031 While rst_i is 1, the following SHALL hold: FSM in IDLE, FIFO empty, count_o = 0, in_ready_o = 1, core_valid_o = 0, core_a_o = core_b_o = 0, res_valid_o = 0, res_gcd_o = 0, err_o = 0.
REQ-032 Reset mid-operation discards all FIFO entries and any in-flight result; a core_valid_i arriving after reset release is ignored per REQ-026.

Configuration
REQ-033 With macro GCD_DISPATCH_TIMEOUT_EN defined, the following SHALL apply:
- A cycle counter starts at ISSUE.
- If WAIT persists for TIMEOUT cycles without core_valid_i, err_o sets (sticky until reset), the operation is dropped and the FSM returns to IDLE.
- No result is produced for the dropped operation.
REQ-034 Without GCD_DISPATCH_TIMEOUT_EN, the block SHALL contain no counter logic, WAIT persists indefinitely and err_o is tied to 0.

Verification
REQ-035 Single op: push (12,18) with res_ready_i = 1 -> one core_valid_o pulse with core_a_o = 12, core_b_o = 18; res_gcd_o = 6 with res_valid_o high for 1 cycle.
REQ-036 Back-to-back: push (6,2), (9,12), (18,12), (0,5) -> results 2, 3, 6, 5 in order; never more than one op outstanding.
REQ-037 Full/backpressure: res_ready_i = 0 and push DEPTH+2 pairs -> the following SHALL be observed:
- in_ready_o drops when count_o reaches DEPTH.
- After the first result, no further core_valid_o until res_ready_i rises.
- No entry is lost.
REQ-038 Simultaneous push and pop at count_o = 2 -> count_o stays 2 and FIFO order is preserved.
REQ-039 Reset asserted during WAIT -> all outputs take reset values at once; a late core_valid_i produces no result.
REQ-040 With GCD_DISPATCH_TIMEOUT_EN and TIMEOUT = 16, a core stub that never responds -> err_o = 1 after 16 WAIT cycles, FSM returns to IDLE, and the next queued op issues.

Source files
------------

// File: rtl/gcd_dispatch.sv
// Operand FIFO and single-outstanding dispatcher in front of a GCD core.
// Optional WAIT watchdog: define GCD_DISPATCH_TIMEOUT_EN.
`timescale 1ns/1ps

module gcd_dispatch #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_a_i,
  input  logic [WIDTH-1:0]         in_b_i,
  output logic                     core_valid_o,
  output logic [WIDTH-1:0]         core_a_o,
  output logic [WIDTH-1:0]         core_b_o,
  input  logic                     core_valid_i,
  input  logic [WIDTH-1:0]         core_gcd_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_gcd_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ready_q;
  logic             core_valid_q;
  logic [WIDTH-1:0] core_a_q;
  logic [WIDTH-1:0] core_b_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_gcd_q;
  logic             push;
  logic             pop;

  assign push = in_valid_i & ready_q;
  assign pop  = (state_q == IDLE) & (count_q != '0) & ~res_valid_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a_i;
      mem_b_q[wr_ptr_q] <= in_b_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

`ifdef GCD_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      core_valid_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      res_valid_q  <= 1'b0;
      res_gcd_q    <= '0;
`ifdef GCD_DISPATCH_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            core_a_q     <= mem_a_q[rd_ptr_q];
            core_b_q     <= mem_b_q[rd_ptr_q];
            core_valid_q <= 1'b1;
            state_q      <= ISSUE;
`ifdef GCD_DISPATCH_TIMEOUT_EN
            tmo_q        <= '0;
`endif
          end
        end
        ISSUE: begin
          core_valid_q <= 1'b0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (core_valid_i) begin
            res_gcd_q   <= core_gcd_i;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
`ifdef GCD_DISPATCH_TIMEOUT_EN
          // Give up on a silent core; the operation is dropped.
          else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        HOLD: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o   = ready_q;
  assign count_o      = count_q;
  assign core_valid_o = core_valid_q;
  assign core_a_o     = core_a_q;
  assign core_b_o     = core_b_q;
  assign res_valid_o  = res_valid_q;
  assign res_gcd_o    = res_gcd_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Scoreboard bench for gcd_dispatch with a behavioural GCD core stub.
// Timeout scenario runs when GCD_DISPATCH_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_gcd_dispatch;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int TMO = 16;
  localparam int CW  = $clog2(D) + 1;
  localparam int RB  = CW + 3 * W + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready_o;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          core_valid_o;
  logic [W-1:0]  core_a_o;
  logic [W-1:0]  core_b_o;
  logic          core_valid_i = 1'b0;
  logic [W-1:0]  core_gcd_i = '0;
  logic          res_valid_o;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_gcd_o;
  logic [CW-1:0] count_o;
  logic          err_o;

  gcd_dispatch #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .core_valid_o (core_valid_o),
    .core_a_o     (core_a_o),
    .core_b_o     (core_b_o),
    .core_valid_i (core_valid_i),
    .core_gcd_i   (core_gcd_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready),
    .res_gcd_o    (res_gcd_o),
    .count_o      (count_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [W-1:0]   expq [$];
  logic [2*W-1:0] opq [$];
  int             rd_idx = 0;
  int             iss_idx = 0;
  int             outstanding = 0;
  int             nres = 0;
  bit             seen = 0;
  logic [W-1:0]   held = '0;

  int             stub_delay = 0;
  bit             stub_respond = 1;
  bit             inject = 0;
  bit             s_pend = 0;
  int             s_dly = 0;
  logic [W-1:0]   s_a = '0;
  logic [W-1:0]   s_b = '0;

  logic [RB-1:0]  rst_obs;
  logic [RB-1:0]  rst_exp;
  assign rst_obs = {in_ready_o, count_o, core_valid_o, core_a_o, core_b_o,
                    res_valid_o, res_gcd_o, err_o};
  assign rst_exp = {1'b1, {(RB-1){1'b0}}};

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core stub: latches operands on the issue pulse, answers during WAIT.
  always @(negedge clk) begin
    if (rst) begin
      s_pend       = 0;
      core_valid_i = 1'b0;
    end else begin
      core_valid_i = 1'b0;
      if (s_pend) begin
        if (s_dly == 0) begin
          s_pend = 0;
          if (stub_respond) begin
            core_valid_i = 1'b1;
            core_gcd_i   = gcd_ref(s_a, s_b);
          end
        end else begin
          s_dly--;
        end
      end
      if (inject) begin
        core_valid_i = 1'b1;
        core_gcd_i   = 8'hAA;
      end
      if (core_valid_o) begin
        s_a    = core_a_o;
        s_b    = core_b_o;
        s_pend = 1;
        s_dly  = stub_delay;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (core_valid_o) begin
      checks++;
      if (outstanding != 0 || iss_idx >= opq.size())
        $display("FAIL issue_extra: outstanding=%0d issued=%0d queued=%0d",
                 outstanding, iss_idx, opq.size());
      else if ({core_a_o, core_b_o} !== opq[iss_idx])
        $display("FAIL issue_operands: got a=%0d b=%0d want a=%0d b=%0d",
                 core_a_o, core_b_o, opq[iss_idx][2*W-1:W], opq[iss_idx][W-1:0]);
      else
        passed++;
      iss_idx++;
      outstanding = 1;
    end
    if (res_valid_o) begin
      checks++;
      if (!seen) begin
        if (rd_idx >= expq.size())
          $display("FAIL res_extra: got %0d with no expected result", res_gcd_o);
        else if (res_gcd_o !== expq[rd_idx])
          $display("FAIL res_value: got %0d want %0d", res_gcd_o, expq[rd_idx]);
        else
          passed++;
        rd_idx++;
        nres++;
        seen = 1;
        held = res_gcd_o;
        outstanding = 0;
      end else begin
        if (res_gcd_o !== held)
          $display("FAIL res_stable: got %0d want %0d", res_gcd_o, held);
        else
          passed++;
      end
    end else begin
      seen = 0;
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int max_cyc);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < max_cyc && !done; i++) begin
      if (in_ready_o) begin
        expq.push_back(gcd_ref(a, b));
        opq.push_back({a, b});
        done = 1;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!done) $display("FAIL push_accept: a=%0d b=%0d not accepted in %0d cycles", a, b, max_cyc);
    else passed++;
  endtask

  task automatic drain(input int max_cyc, input bit rnd_ready);
    int i;
    i = 0;
    while (!(rd_idx == expq.size() && count_o == 0 && outstanding == 0 &&
             !res_valid_o) && i < max_cyc) begin
      if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
      step();
      i++;
    end
    res_ready = 1'b1;
    checks++;
    if (i >= max_cyc)
      $display("FAIL drain: pending=%0d count=%0d after %0d cycles",
               expq.size() - rd_idx, count_o, i);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (rst_obs !== rst_exp) $display("FAIL reset_outputs: got %h want %h", rst_obs, rst_exp);
    else passed++;
    rst = 1'b0;
    step();
    checks++;
    if (rst_obs !== rst_exp) $display("FAIL post_reset_idle: got %h want %h", rst_obs, rst_exp);
    else passed++;
  endtask

  task automatic test_single();
    int n0, i0, lat;
    n0 = nres;
    i0 = iss_idx;
    stub_delay = 0;
    stub_respond = 1;
    res_ready = 1'b1;
    push(8'd12, 8'd18, 4);
    lat = 0;
    while (!res_valid_o && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 3) $display("FAIL single_latency: got %0d want 3", lat);
    else passed++;
    checks++;
    if (nres - n0 != 1 || iss_idx - i0 != 1)
      $display("FAIL single_counts: results=%0d issues=%0d want 1/1", nres - n0, iss_idx - i0);
    else passed++;
    step();
    checks++;
    if (res_valid_o !== 1'b0) $display("FAIL single_pulse: res_valid=%b want 0", res_valid_o);
    else passed++;
    drain(50, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    int n0;
    ta = '{8'd6, 8'd9, 8'd18, 8'd0};
    tb = '{8'd2, 8'd12, 8'd12, 8'd5};
    n0 = nres;
    res_ready = 1'b1;
    stub_delay = 2;
    for (int k = 0; k < 4; k++) push(ta[k], tb[k], 100);
    drain(200, 0);
    checks++;
    if (nres - n0 != 4) $display("FAIL b2b_count: got %0d want 4", nres - n0);
    else passed++;
    n0 = nres;
    for (int k = 0; k < 12; k++) begin
      stub_delay = $urandom_range(0, 4);
      push(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)), 200);
    end
    drain(1000, 1);
    checks++;
    if (nres - n0 != 12) $display("FAIL rand_count: got %0d want 12", nres - n0);
    else passed++;
    checks++;
    if (err_o !== 1'b0) $display("FAIL err_quiet: got %b want 0", err_o);
    else passed++;
  endtask

  task automatic test_backpressure();
    int n0, i0;
    bit bad, acc;
    n0 = nres;
    i0 = iss_idx;
    res_ready = 1'b0;
    stub_delay = 0;
    for (int k = 0; k < D + 1; k++) push(W'(10 + 3 * k), W'(4 + 2 * k), 4);
    repeat (3) step();
    checks++;
    if (count_o !== CW'(D) || in_ready_o !== 1'b0 || res_valid_o !== 1'b1)
      $display("FAIL bp_full: count=%0d ready=%b res_valid=%b want %0d/0/1",
               count_o, in_ready_o, res_valid_o, D);
    else passed++;
    in_valid = 1'b1;
    in_a = 8'd77;
    in_b = 8'd33;
    bad = 0;
    repeat (6) begin
      step();
      if (in_ready_o !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || iss_idx - i0 != 1)
      $display("FAIL bp_stall: ready_seen=%b issues=%0d want 0/1", bad, iss_idx - i0);
    else passed++;
    res_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (in_ready_o) begin
        expq.push_back(gcd_ref(8'd77, 8'd33));
        opq.push_back({8'd77, 8'd33});
        acc = 1;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) $display("FAIL bp_resume: held push never accepted");
    else passed++;
    drain(300, 0);
    checks++;
    if (nres - n0 != D + 2) $display("FAIL bp_count: got %0d want %0d", nres - n0, D + 2);
    else passed++;
  endtask

  task automatic test_simul();
    int n0;
    n0 = nres;
    res_ready = 1'b0;
    stub_delay = 0;
    push(8'd20, 8'd8, 4);
    push(8'd21, 8'd14, 4);
    push(8'd27, 8'd18, 4);
    repeat (3) step();
    checks++;
    if (count_o !== CW'(2) || res_valid_o !== 1'b1)
      $display("FAIL simul_setup: count=%0d res_valid=%b want 2/1", count_o, res_valid_o);
    else passed++;
    res_ready = 1'b1;
    step();
    checks++;
    if (count_o !== CW'(2) || res_valid_o !== 1'b0)
      $display("FAIL simul_idle: count=%0d res_valid=%b want 2/0", count_o, res_valid_o);
    else passed++;
    push(8'd35, 8'd15, 1);
    checks++;
    if (count_o !== CW'(2) || core_valid_o !== 1'b1)
      $display("FAIL simul_pushpop: count=%0d core_valid=%b want 2/1", count_o, core_valid_o);
    else passed++;
    drain(200, 0);
    checks++;
    if (nres - n0 != 4) $display("FAIL simul_count: got %0d want 4", nres - n0);
    else passed++;
  endtask

`ifdef GCD_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int n0, i0, t;
    n0 = nres;
    i0 = iss_idx;
    res_ready = 1'b1;
    stub_respond = 0;
    stub_delay = 0;
    push(8'd40, 8'd24, 4);
    t = 0;
    while (iss_idx == i0 && t < 10) begin
      step();
      t++;
    end
    push(8'd14, 8'd21, 4);
    t = 1;
    while (!err_o && t < 100) begin
      step();
      t++;
    end
    checks++;
    if (t != TMO + 1) $display("FAIL tmo_latency: err after %0d cycles want %0d", t, TMO + 1);
    else passed++;
    stub_respond = 1;
    outstanding = 0;
    rd_idx++;
    drain(200, 0);
    checks++;
    if (nres - n0 != 1 || err_o !== 1'b1)
      $display("FAIL tmo_next: results=%0d err=%b want 1/1", nres - n0, err_o);
    else passed++;
  endtask
`endif

  task automatic test_reset_wait();
    int i0, t;
    bit bad;
    i0 = iss_idx;
    res_ready = 1'b1;
    stub_respond = 0;
    stub_delay = 0;
    push(8'd30, 8'd12, 4);
    push(8'd9, 8'd3, 4);
    t = 0;
    while (iss_idx == i0 && t < 10) begin
      step();
      t++;
    end
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rst_obs !== rst_exp) $display("FAIL reset_async: got %h want %h", rst_obs, rst_exp);
    else passed++;
    rd_idx = expq.size();
    iss_idx = opq.size();
    outstanding = 0;
    seen = 0;
    step();
    rst = 1'b0;
    @(posedge clk);
    #1 inject = 1;
    @(posedge clk);
    #1 inject = 0;
    bad = 0;
    repeat (8) begin
      step();
      if (res_valid_o || core_valid_o || count_o != 0) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL reset_late_resp: activity after reset got 1 want 0");
    else passed++;
    stub_respond = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simul();
`ifdef GCD_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
